// File: rtl/gf180mcu_clk_activity_monitor.sv
// Counts rising edges of an asynchronous clock I over fixed CLK windows and flags loss / too-fast / in-range.
// Optional: define CLKMON_STICKY_EN to make LOSS and FAST sticky until EN drops or RN is asserted.
module gf180mcu_clk_activity_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WINDOW      = 200,
    parameter int unsigned WIN_W       = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MIN_EDGES   = 40,
    parameter int unsigned MAX_EDGES   = 60
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             I,
    output logic [CNT_W-1:0] CNT,
    output logic             VALID,
    output logic             LOSS,
    output logic             FAST,
    output logic             OK
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic [WIN_W-1:0]       wc_reg;
    logic [CNT_W-1:0]       ec_reg;

    logic                   rise_strobe;
    logic [CNT_W-1:0]       ec_next;
    logic                   loss_win;
    logic                   fast_win;
    logic                   loss_next;
    logic                   fast_next;

    assign rise_strobe = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    always_comb begin
        ec_next = ec_reg;
        if (rise_strobe && (ec_reg != CNT_MAX)) begin
            ec_next = ec_reg + 1'b1;
        end
    end

    // Thresholds are compared at full parameter width so a limit above the
    // counter range can never be reached rather than wrapping.
    assign loss_win = (32'(ec_next) < MIN_EDGES);
    assign fast_win = (32'(ec_next) > MAX_EDGES);

`ifdef CLKMON_STICKY_EN
    assign loss_next = LOSS | loss_win;
    assign fast_next = FAST | fast_win;
`else
    assign loss_next = loss_win;
    assign fast_next = fast_win;
`endif

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_reg <= IDLE;
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            wc_reg    <= '0;
            ec_reg    <= '0;
            CNT       <= '0;
            VALID     <= 1'b0;
            LOSS      <= 1'b0;
            FAST      <= 1'b0;
            OK        <= 1'b0;
        end else begin
            // Synchronizer and prev run in every state so no false edge on entry.
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], I};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            VALID    <= 1'b0;

            case (state_reg)
                IDLE: begin
                    wc_reg <= '0;
                    ec_reg <= '0;
                    if (EN) begin
                        state_reg <= MEASURE;
                    end
                end

                MEASURE: begin
                    if (!EN) begin
                        state_reg <= IDLE;
                        wc_reg    <= '0;
                        ec_reg    <= '0;
`ifdef CLKMON_STICKY_EN
                        LOSS      <= 1'b0;
                        FAST      <= 1'b0;
                        OK        <= 1'b1;
`endif
                    end else if (wc_reg == WIN_LAST) begin
                        // Last window cycle: its edge is included in the report.
                        state_reg <= REPORT;
                        CNT       <= ec_next;
                        LOSS      <= loss_next;
                        FAST      <= fast_next;
                        OK        <= ~loss_next & ~fast_next;
                        VALID     <= 1'b1;
                        wc_reg    <= '0;
                        ec_reg    <= '0;
                    end else begin
                        wc_reg <= wc_reg + 1'b1;
                        ec_reg <= ec_next;
                    end
                end

                REPORT: begin
                    // Edges seen during this single cycle are intentionally dropped.
                    wc_reg <= '0;
                    ec_reg <= '0;
                    if (EN) begin
                        state_reg <= MEASURE;
                    end else begin
                        state_reg <= IDLE;
`ifdef CLKMON_STICKY_EN
                        LOSS      <= 1'b0;
                        FAST      <= 1'b0;
                        OK        <= 1'b1;
`endif
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    wc_reg    <= '0;
                    ec_reg    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_clk_activity_monitor.sv
// Directed bench for gf180mcu_clk_activity_monitor: default instance plus a 5-bit saturating instance.
module tb_gf180mcu_clk_activity_monitor;

    logic       clk    = 1'b0;
    logic       rn     = 1'b0;
    logic       en     = 1'b0;
    logic       i_sig  = 1'b0;

    logic [7:0] cnt;
    logic       valid;
    logic       loss;
    logic       fast;
    logic       ok;

    logic [4:0] s_cnt;
    logic       s_valid;
    logic       s_loss;
    logic       s_fast;
    logic       s_ok;

    int checks = 0;
    int errors = 0;

    // I generator: i_half==0 holds i_stuck, otherwise toggles every i_half CLK cycles.
    int   i_half  = 0;
    logic i_stuck = 1'b0;
    int   i_ctr   = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_half == 0) begin
            i_sig <= i_stuck;
            i_ctr <= 0;
        end else if (i_ctr + 1 >= i_half) begin
            i_ctr <= 0;
            i_sig <= ~i_sig;
        end else begin
            i_ctr <= i_ctr + 1;
        end
    end

    gf180mcu_clk_activity_monitor u_dut (
        .CLK   (clk),
        .RN    (rn),
        .EN    (en),
        .I     (i_sig),
        .CNT   (cnt),
        .VALID (valid),
        .LOSS  (loss),
        .FAST  (fast),
        .OK    (ok)
    );

    gf180mcu_clk_activity_monitor #(
        .CNT_W     (5),
        .MIN_EDGES (10),
        .MAX_EDGES (20)
    ) u_sat (
        .CLK   (clk),
        .RN    (rn),
        .EN    (en),
        .I     (i_sig),
        .CNT   (s_cnt),
        .VALID (s_valid),
        .LOSS  (s_loss),
        .FAST  (s_fast),
        .OK    (s_ok)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits up to max_cyc CLK cycles for VALID; cyc is the cycle it arrived on (-1 on timeout).
    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = -1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                cyc = n;
                break;
            end
        end
        check_val("valid_seen", {31'd0, valid}, 32'd1);
        $display("window: cyc=%0d cnt=%0d loss=%0d fast=%0d ok=%0d sat_cnt=%0d",
                 cyc, cnt, loss, fast, ok, s_cnt);
    endtask

    initial begin
        int cyc;
        int nv;

        // Reset state
        rn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cnt",   32'(cnt),  32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_loss",  32'(loss), 32'd0);
        check_val("rst_fast",  32'(fast), 32'd0);
        check_val("rst_ok",    32'(ok),   32'd0);

        // Nominal: I period 4 -> 50 edges per window
        @(negedge clk);
        rn     = 1'b1;
        i_half = 2;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_valid(400, cyc);
        check_val("first_valid_latency", 32'(cyc), 32'd201);
        check_val("nom_cnt",  32'(cnt),  32'd50);
        check_val("nom_ok",   32'(ok),   32'd1);
        check_val("nom_loss", 32'(loss), 32'd0);
        check_val("nom_fast", 32'(fast), 32'd0);
        @(posedge clk);
        #1;
        check_val("valid_one_cycle", 32'(valid), 32'd0);
        wait_valid(400, cyc);
        check_val("valid_period", 32'(cyc), 32'd200);
        check_val("nom_cnt2", 32'(cnt), 32'd50);

        // I stuck low
        @(negedge clk);
        i_half  = 0;
        i_stuck = 1'b0;
        wait_valid(400, cyc);
        wait_valid(400, cyc);
        check_val("stuck0_cnt",  32'(cnt),   32'd0);
        check_val("stuck0_loss", 32'(loss),  32'd1);
        check_val("stuck0_ok",   32'(ok),    32'd0);
        check_val("stuck0_fast", 32'(fast),  32'd0);
        check_val("stuck0_sat_cnt", 32'(s_cnt), 32'd0);

        // I stuck high
        @(negedge clk);
        i_stuck = 1'b1;
        wait_valid(400, cyc);
        wait_valid(400, cyc);
        check_val("stuck1_cnt",  32'(cnt),  32'd0);
        check_val("stuck1_loss", 32'(loss), 32'd1);
        check_val("stuck1_ok",   32'(ok),   32'd0);

        // I period 2 -> 100 edges, and saturation on the 5-bit instance
        @(negedge clk);
        i_half = 1;
        wait_valid(400, cyc);
        wait_valid(400, cyc);
        check_val("fast_cnt",  32'(cnt),  32'd100);
        check_val("fast_fast", 32'(fast), 32'd1);
        check_val("fast_ok",   32'(ok),   32'd0);
        check_val("fast_loss", 32'(loss), 32'd0);
        check_val("sat_cnt",   32'(s_cnt),  32'd31);
        check_val("sat_fast",  32'(s_fast), 32'd1);
        check_val("sat_ok",    32'(s_ok),   32'd0);

        // EN dropped mid-window: no report, outputs hold (cleared when sticky)
        @(negedge clk);
        i_half = 2;
        repeat (100) @(negedge clk);
        en = 1'b0;
        nv = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check_val("drop_no_valid", 32'(nv),  32'd0);
        check_val("drop_cnt_hold", 32'(cnt), 32'd100);
`ifdef CLKMON_STICKY_EN
        check_val("drop_fast", 32'(fast), 32'd0);
        check_val("drop_ok",   32'(ok),   32'd1);
`else
        check_val("drop_fast", 32'(fast), 32'd1);
        check_val("drop_ok",   32'(ok),   32'd0);
`endif
        @(negedge clk);
        en = 1'b1;
        wait_valid(400, cyc);
        check_val("rearm_latency", 32'(cyc),  32'd201);
        check_val("rearm_cnt",     32'(cnt),  32'd50);
        check_val("rearm_ok",      32'(ok),   32'd1);
        check_val("rearm_fast",    32'(fast), 32'd0);

        // Asynchronous reset mid-window
        repeat (50) @(negedge clk);
        rn = 1'b0;
        #1;
        check_val("arst_cnt",   32'(cnt),   32'd0);
        check_val("arst_ok",    32'(ok),    32'd0);
        check_val("arst_valid", 32'(valid), 32'd0);
        check_val("arst_loss",  32'(loss),  32'd0);

        // Stuck window followed by nominal windows: sticky vs. latest-window flags
        en      = 1'b0;
        i_half  = 0;
        i_stuck = 1'b0;
        repeat (10) @(negedge clk);
        rn = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_valid(400, cyc);
        check_val("seq_stuck_cnt",  32'(cnt),  32'd0);
        check_val("seq_stuck_loss", 32'(loss), 32'd1);
        @(negedge clk);
        i_half = 2;
        wait_valid(400, cyc);
        wait_valid(400, cyc);
        check_val("seq_nom_cnt", 32'(cnt), 32'd50);
`ifdef CLKMON_STICKY_EN
        check_val("seq_loss", 32'(loss), 32'd1);
        check_val("seq_ok",   32'(ok),   32'd0);
`else
        check_val("seq_loss", 32'(loss), 32'd0);
        check_val("seq_ok",   32'(ok),   32'd1);
`endif
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        check_val("en_pulse_loss", 32'(loss), 32'd0);
        check_val("en_pulse_ok",   32'(ok),   32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
